// File: rtl/pu_input_buffer.sv
// -----------------------------------------------------------------------------
// pu_input_buffer
//
// Read-side input FIFO sitting directly upstream of the PU datapath and its
// PU_controller. Words of 4 x 16-bit operands arrive from the memory/DMA side,
// each tagged with a "last" flag. They are served to the PU through a pop
// handshake with a registered one-cycle read latency. This decouples memory
// burst timing from the PE compute schedule.
//
// Optional feature macro: PU_IBUF_ERR_EN
//   When defined, the outputs err_overflow and err_underflow are added. Both
//   are sticky and are cleared by reset or flush.
//
// Ports
//   clk                     in   rising-edge clock
//   reset                   in   synchronous, active-low reset
//   flush                   in   synchronous clear of FIFO contents (layer boundary)
//   mem_wr_data             in   word from the memory side
//   mem_wr_last             in   word ends a burst/layer stream
//   mem_wr_valid            in   write strobe
//   mem_wr_ready            out  FIFO can accept a word this cycle
//   mem_wr_afull            out  occupancy >= AFULL_LVL
//   buffer_read_req         in   pop request from PU_controller
//   buffer_read_data_out    out  popped word; holds its value between pops
//   buffer_read_data_valid  out  one-cycle pulse per accepted pop
//   buffer_read_last        out  popped word carried mem_wr_last (0 when not valid)
//   buffer_read_empty       out  no word available to pop
//   occupancy               out  words currently stored
//   err_overflow            out  (PU_IBUF_ERR_EN) write attempted while full
//   err_underflow           out  (PU_IBUF_ERR_EN) pop attempted while empty
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module pu_input_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_W     = 4,
  parameter int AFULL_LVL  = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic                  mem_wr_last,
  input  logic                  mem_wr_valid,
  output logic                  mem_wr_ready,
  output logic                  mem_wr_afull,
  input  logic                  buffer_read_req,
  output logic [DATA_WIDTH-1:0] buffer_read_data_out,
  output logic                  buffer_read_data_valid,
  output logic                  buffer_read_last,
  output logic                  buffer_read_empty,
  output logic [ADDR_W:0]       occupancy
`ifdef PU_IBUF_ERR_EN
  ,
  output logic                  err_overflow,
  output logic                  err_underflow
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  // Pointer increment and almost-full threshold sized to the pointer width.
  localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] AFULL_CMP = AFULL_LVL[ADDR_W:0];

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_last_q, rd_last_d;

  // Bit DATA_WIDTH of each entry holds the last tag.
  logic [DATA_WIDTH:0]   mem_q [DEPTH];

`ifdef PU_IBUF_ERR_EN
  logic                  err_ovf_q, err_ovf_d;
  logic                  err_unf_q, err_unf_d;
`endif

  // ---------------------------------------------------------------------------
  // Flags, all derived from registered pointers (no fall-through)
  // ---------------------------------------------------------------------------
  logic              full;
  logic              empty;
  logic              wr_fire;
  logic              rd_fire;
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] rd_idx;

  assign wr_idx = wr_ptr_q[ADDR_W-1:0];
  assign rd_idx = rd_ptr_q[ADDR_W-1:0];

  // The extra pointer MSB tells a wrapped-full FIFO apart from an empty one.
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) && (wr_idx == rd_idx);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Flush discards any write or pop presented in the same cycle.
  assign wr_fire = mem_wr_valid    && !full  && !flush;
  assign rd_fire = buffer_read_req && !empty && !flush;

  // ---------------------------------------------------------------------------
  // Control FSM: a flush sends the buffer through one FLUSH cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (flush) state_d = ST_FLUSH;
      ST_FLUSH: state_d = flush ? ST_FLUSH : ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;

    if (flush) begin
      // Pointers cleared; a pop in flight this cycle never produces valid.
      // data_out keeps its last popped value.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_fire) begin
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        rd_data_d  = mem_q[rd_idx][DATA_WIDTH-1:0];
        rd_last_d  = mem_q[rd_idx][DATA_WIDTH];
        rd_valid_d = 1'b1;
      end
    end
  end

`ifdef PU_IBUF_ERR_EN
  always_comb begin
    err_ovf_d = err_ovf_q;
    err_unf_d = err_unf_q;
    if (flush) begin
      err_ovf_d = 1'b0;
      err_unf_d = 1'b0;
    end else begin
      if (mem_wr_valid && full)     err_ovf_d = 1'b1;
      if (buffer_read_req && empty) err_unf_d = 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

`ifdef PU_IBUF_ERR_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end
`endif

  // NOTE: the storage array has no reset; stale entries are unreachable
  // because the pointers are reset, and this lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (reset && wr_fire) mem_q[wr_idx] <= {mem_wr_last, mem_wr_data};
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign occupancy              = wr_ptr_q - rd_ptr_q;
  assign mem_wr_ready           = !full;
  assign mem_wr_afull           = (occupancy >= AFULL_CMP);
  assign buffer_read_empty      = empty;
  assign buffer_read_data_out   = rd_data_q;
  assign buffer_read_data_valid = rd_valid_q;
  assign buffer_read_last       = rd_last_q;

`ifdef PU_IBUF_ERR_EN
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;
`endif

endmodule
